// File: rtl/br_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_ctrl_pkg
// Description : Shared types for the branch update controller: the update
//               FSM state encoding and the in-flight branch queue entry.
// Revision    : 1.0 - initial release
// ============================================================================
package br_ctrl_pkg;

  // Widest PC the queue entry can carry; the top-level PC_W must not exceed it.
  localparam int BR_PC_W = 32;

  typedef enum logic [1:0] {
    UPD_IDLE  = 2'd0,
    UPD_PULSE = 2'd1,
    UPD_GAP   = 2'd2
  } upd_state_t;

  typedef struct packed {
    logic               pred;    // direction predicted at fetch
    logic [BR_PC_W-1:0] alt_pc;  // PC of the path that was not predicted
  } br_entry_t;

endpackage : br_ctrl_pkg
`default_nettype wire

// File: rtl/br_fifo.sv
`default_nettype none
// ============================================================================
// Module      : br_fifo
// Description : Synchronous FIFO holding in-flight branch entries. Clear has
//               priority over push and pop. Pointers wrap mod DEPTH.
// Ports       : clk, rst_n   - clock / async active-low reset
//               clear_i      - empty the FIFO this edge
//               push_i/wdata_i - write an entry
//               pop_i        - drop the head entry
//               rdata_o      - head entry (valid when count_o != 0)
//               count_o      - number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module br_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : br_fifo
`default_nettype wire

// File: rtl/branch_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_update_ctrl
// Description : Sequences updates of the global 2-bit branch predictor.
//               Queues each fetched branch's prediction and alternate PC,
//               compares the oldest entry against the EX resolution, raises
//               flush/redirect on a mispredict and emits isolated 1-cycle
//               pre_right/pre_wrong pulses (held off while stalled).
// Ports       : clk, rst_n          - clock / async active-low reset
//               stall               - pipeline stall, gates predictor pulses
//               br_pre              - predictor direction, sampled at push
//               bp_valid/bp_alt_pc  - IF: branch issued + alternate PC
//               bp_ready            - queue not full
//               res_valid/res_taken - EX: oldest branch resolved + direction
//               res_ready           - resolution can be accepted
//               pre_right/pre_wrong - predictor update pulses
//               flush/redirect_pc   - mispredict squash + fetch target
//               err_underflw        - sticky: resolution with empty queue
// Revision    : 1.0 - initial release
// ============================================================================
module branch_update_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_pre,
  input  logic            bp_valid,
  input  logic [PC_W-1:0] bp_alt_pc,
  output logic            bp_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic            res_ready,
  output logic            pre_right,
  output logic            pre_wrong,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            err_underflw
);

  localparam int CW = $clog2(DEPTH) + 1;

  // --------------------------------------------------------------------------
  // Branch queue
  // --------------------------------------------------------------------------
  br_entry_t       wentry;
  br_entry_t       head;
  logic [CW-1:0]   count;
  logic            q_empty;
  logic            accept;
  logic            mis;
  logic            q_clear;
  logic            push;

  logic            pend_v_q,     pend_v_d;
  logic            pend_wrong_q, pend_wrong_d;
  upd_state_t      state_q,      state_d;
  logic            flush_q;
  logic [PC_W-1:0] redirect_q;
  logic            err_q;

  always_comb begin
    wentry        = '0;
    wentry.pred   = br_pre;
    wentry.alt_pc = BR_PC_W'(bp_alt_pc);
  end

  assign q_empty   = (count == '0);
  assign bp_ready  = (count < CW'(DEPTH));
  // Low while a predictor update is outstanding (back-pressure) or while
  // there is nothing in flight to resolve.
  assign res_ready = !pend_v_q && !q_empty;
  assign accept    = res_valid && res_ready;
  assign mis       = head.pred ^ res_taken;
  // A mispredict squashes every younger branch, including one fetched in the
  // same cycle, so the push is suppressed rather than racing the clear.
  assign q_clear   = accept && mis;
  assign push      = bp_valid && bp_ready && !q_clear;

  br_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(br_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (q_clear),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (accept),
    .rdata_o (head),
    .count_o (count)
  );

  // --------------------------------------------------------------------------
  // Pending-update register
  // --------------------------------------------------------------------------
  always_comb begin
    pend_v_d     = pend_v_q;
    pend_wrong_d = pend_wrong_q;
    if (state_q == UPD_PULSE && !stall) pend_v_d = 1'b0;
    // Accept only happens with pend_v_q=0, so it never collides with the clear.
    if (accept) begin
      pend_v_d     = 1'b1;
      pend_wrong_d = mis;
    end
  end

  // --------------------------------------------------------------------------
  // Update FSM: IDLE -> PULSE (held while stalled) -> GAP -> IDLE. The GAP
  // cycle guarantees the predictor sees a low cycle between two events.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pre_right = 1'b0;
    pre_wrong = 1'b0;
    case (state_q)
      UPD_IDLE: begin
        if (pend_v_q) state_d = UPD_PULSE;
      end
      UPD_PULSE: begin
        if (!stall) begin
          pre_wrong = pend_wrong_q;
          pre_right = !pend_wrong_q;
          state_d   = UPD_GAP;
        end
      end
      UPD_GAP: begin
        state_d = UPD_IDLE;
      end
      default: begin
        state_d = UPD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UPD_IDLE;
      pend_v_q     <= 1'b0;
      pend_wrong_q <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_v_q     <= pend_v_d;
      pend_wrong_q <= pend_wrong_d;
      flush_q      <= q_clear;
      if (q_clear) redirect_q <= PC_W'(head.alt_pc);
      if (res_valid && q_empty) err_q <= 1'b1;
    end
  end

  assign flush        = flush_q;
  assign redirect_pc  = redirect_q;
  assign err_underflw = err_q;

endmodule : branch_update_ctrl
`default_nettype wire

// File: tb/tb_branch_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_update_ctrl
// Description : Self-checking bench for branch_update_ctrl. A reference model
//               (a queue of branches plus a timestamped pending update) runs
//               alongside directed tables, hand sequences and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_update_ctrl;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall = 1'b0;
  logic            br_pre = 1'b0;
  logic            bp_valid = 1'b0;
  logic [PC_W-1:0] bp_alt_pc = '0;
  logic            bp_ready;
  logic            res_valid = 1'b0;
  logic            res_taken = 1'b0;
  logic            res_ready;
  logic            pre_right;
  logic            pre_wrong;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;
  logic            err_underflw;

  branch_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_pre       (br_pre),
    .bp_valid     (bp_valid),
    .bp_alt_pc    (bp_alt_pc),
    .bp_ready     (bp_ready),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .res_ready    (res_ready),
    .pre_right    (pre_right),
    .pre_wrong    (pre_wrong),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .err_underflw (err_underflw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit          pred;
    logic [31:0] alt;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;
  bit          m_pwrong;
  int          m_elig;     // first cycle the pending update may pulse
  bit          m_flush;
  logic [31:0] m_redir;
  bit          m_err;
  int          cyc = 0;

  task automatic model_reset();
    mq.delete();
    m_pend  = 0;
    m_pwrong = 0;
    m_elig  = 0;
    m_flush = 0;
    m_redir = '0;
    m_err   = 0;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        bv, bp;
    logic [31:0] alt;
    logic        rv, rt, st;
    logic        chk;
    logic        e_bpr, e_rr, e_pr, e_pw, e_fl;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t V(logic bv, logic bp, logic [31:0] alt, logic rv, logic rt,
                             logic st, logic chk, logic e_bpr, logic e_rr, logic e_pr,
                             logic e_pw, logic e_fl, logic [31:0] e_rd);
    vec_t v;
    v.bv = bv; v.bp = bp; v.alt = alt; v.rv = rv; v.rt = rt; v.st = st; v.chk = chk;
    v.e_bpr = e_bpr; v.e_rr = e_rr; v.e_pr = e_pr; v.e_pw = e_pw; v.e_fl = e_fl;
    v.e_rd = e_rd;
    return v;
  endfunction

  // Inputs only, no table expectations.
  function automatic vec_t I(logic bv, logic bp, logic [31:0] alt, logic rv, logic rt,
                             logic st);
    return V(bv, bp, alt, rv, rt, st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  // Last sampled DUT outputs, for sequence-level checks.
  logic s_bpr, s_rr, s_pr, s_pw, s_err;

  // One clock cycle: drive at negedge, sample 2ns later, advance model at posedge.
  task automatic step(input vec_t v);
    bit   exp_bpr, exp_rr, fire, mis;
    ent_t h;
    ent_t n;
    @(negedge clk);
    bp_valid = v.bv; br_pre = v.bp; bp_alt_pc = v.alt;
    res_valid = v.rv; res_taken = v.rt; stall = v.st;
    #2;
    exp_bpr = (mq.size() < DEPTH);
    exp_rr  = !m_pend && (mq.size() != 0);
    fire    = m_pend && (cyc >= m_elig) && !v.st;
    s_bpr = bp_ready; s_rr = res_ready; s_pr = pre_right; s_pw = pre_wrong;
    s_err = err_underflw;
    check("bp_ready",     bp_ready,     exp_bpr);
    check("res_ready",    res_ready,    exp_rr);
    check("pre_right",    pre_right,    fire && !m_pwrong);
    check("pre_wrong",    pre_wrong,    fire && m_pwrong);
    check("flush",        flush,        m_flush);
    check("redirect_pc",  redirect_pc,  m_redir);
    check("err_underflw", err_underflw, m_err);
    if (v.chk) begin
      check("tbl_bp_ready",  bp_ready,    v.e_bpr);
      check("tbl_res_ready", res_ready,   v.e_rr);
      check("tbl_pre_right", pre_right,   v.e_pr);
      check("tbl_pre_wrong", pre_wrong,   v.e_pw);
      check("tbl_flush",     flush,       v.e_fl);
      check("tbl_redirect",  redirect_pc, v.e_rd);
    end
    @(posedge clk);
    n.pred = v.bp; n.alt = v.alt;
    if (v.rv && mq.size() == 0) m_err = 1;
    if (fire) m_pend = 0;
    m_flush = 0;
    if (v.rv && exp_rr) begin
      h = mq.pop_front();
      mis = h.pred ^ v.rt;
      m_pend = 1; m_pwrong = mis; m_elig = cyc + 2;
      if (mis) begin
        mq.delete();
        m_flush = 1;
        m_redir = h.alt;
      end else if (v.bv && exp_bpr) mq.push_back(n);
    end else if (v.bv && exp_bpr) mq.push_back(n);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; bp_valid = 0; res_valid = 0; stall = 0; br_pre = 0; res_taken = 0;
    bp_alt_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  vec_t tbl[12];
  vec_t idle;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int pulses, last_pc, saw_low, gap_ok, stall_pulses;
    idle = I(0, 0, 32'h0, 0, 0, 0);

    // ---- reset state
    rst_n = 0;
    #1;
    check("rst_bp_ready",  bp_ready,     1'b1);
    check("rst_res_ready", res_ready,    1'b0);
    check("rst_pre_right", pre_right,    1'b0);
    check("rst_pre_wrong", pre_wrong,    1'b0);
    check("rst_flush",     flush,        1'b0);
    check("rst_redirect",  redirect_pc,  32'h0);
    check("rst_err",       err_underflw, 1'b0);
    do_reset();

    // ---- directed table: correct prediction, then mispredict with redirect
    //        bv bp alt        rv rt st chk bpr rr pr pw fl rd
    tbl[0]  = V(1, 1, 32'h40,  0, 0, 0, 1,  1,  0, 0, 0, 0, 32'h0);
    tbl[1]  = V(0, 0, 32'h0,   1, 1, 0, 1,  1,  1, 0, 0, 0, 32'h0);
    tbl[2]  = V(0, 0, 32'h0,   0, 0, 0, 1,  1,  0, 0, 0, 0, 32'h0);
    tbl[3]  = V(0, 0, 32'h0,   0, 0, 0, 1,  1,  0, 1, 0, 0, 32'h0);
    tbl[4]  = V(0, 0, 32'h0,   0, 0, 0, 1,  1,  0, 0, 0, 0, 32'h0);
    tbl[5]  = V(1, 0, 32'h100, 0, 0, 0, 1,  1,  0, 0, 0, 0, 32'h0);
    tbl[6]  = V(0, 0, 32'h0,   1, 1, 0, 1,  1,  1, 0, 0, 0, 32'h0);
    tbl[7]  = V(0, 0, 32'h0,   0, 0, 0, 1,  1,  0, 0, 0, 1, 32'h100);
    tbl[8]  = V(0, 0, 32'h0,   0, 0, 0, 1,  1,  0, 0, 1, 0, 32'h100);
    tbl[9]  = V(0, 0, 32'h0,   0, 0, 0, 1,  1,  0, 0, 0, 0, 32'h100);
    // mispredict with a push in the accept cycle: the push is dropped
    tbl[10] = V(1, 1, 32'h300, 0, 0, 0, 1,  1,  0, 0, 0, 0, 32'h100);
    tbl[11] = V(1, 0, 32'h500, 1, 0, 0, 1,  1,  1, 0, 0, 0, 32'h100);
    for (int i = 0; i < 12; i++) step(tbl[i]);
    step(idle);
    check("drop_push_flush", flush, 1'b1);
    check("drop_push_rd",    redirect_pc, 32'h300);
    check("drop_push_empty", res_ready, 1'b0);

    // ---- fill: push+resolve at count 2 keeps count 2, then full after 2 more
    do_reset();
    step(I(1, 1, 32'hA0, 0, 0, 0));
    step(I(1, 1, 32'hB0, 0, 0, 0));
    step(I(1, 1, 32'hC0, 1, 1, 0));
    step(I(1, 1, 32'hD0, 0, 0, 0));
    step(I(1, 1, 32'hE0, 0, 0, 0));
    check("not_full_at_3", s_bpr, 1'b1);
    step(idle);
    check("full_bp_ready", s_bpr, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(I(0, 0, 32'h0, 1, 1, 0));
      repeat (3) step(idle);
    end
    check("drained_bp_ready", s_bpr, 1'b1);

    // ---- stalled correct resolution
    do_reset();
    step(I(1, 1, 32'h80, 0, 0, 0));
    step(I(0, 0, 32'h0, 1, 1, 1));
    stall_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(I(0, 0, 32'h0, 0, 0, 1));
      stall_pulses += int'(s_pr);
    end
    check("stall_held_low", stall_pulses, 0);
    step(idle);
    check("stall_release_pulse", s_pr, 1'b1);
    step(idle);
    check("stall_pulse_1cyc", s_pr, 1'b0);

    // ---- consecutive correct resolutions are back-pressured
    do_reset();
    step(I(1, 1, 32'h10, 0, 0, 0));
    step(I(1, 1, 32'h20, 0, 0, 0));
    pulses = 0; last_pc = -10; saw_low = 0; gap_ok = 1;
    for (int i = 0; i < 10; i++) begin
      step(I(0, 0, 32'h0, (mq.size() != 0), 1, 0));
      if (res_valid && !s_rr && mq.size() != 0) saw_low = 1;
      if (s_pr) begin
        if (i - last_pc < 3) gap_ok = 0;
        last_pc = i;
        pulses++;
      end
    end
    check("b2b_backpressure", saw_low, 1);
    check("b2b_two_pulses",   pulses, 2);
    check("b2b_pulse_gap",    gap_ok, 1);

    // ---- underflow
    do_reset();
    step(I(0, 0, 32'h0, 1, 1, 0));
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(idle);
      pulses += int'(s_pr) + int'(s_pw);
    end
    check("underflow_sticky", s_err, 1'b1);
    check("underflow_nopulse", pulses, 0);

    // ---- async reset in the middle of a pulse
    do_reset();
    step(I(1, 1, 32'h44, 0, 0, 0));
    step(I(0, 0, 32'h0, 1, 1, 0));
    step(idle);
    @(negedge clk);
    bp_valid = 0; res_valid = 0; stall = 0;
    #2;
    check("arst_pulse_before", pre_right, 1'b1);
    #1 rst_n = 0;
    #1;
    check("arst_pre_right", pre_right, 1'b0);
    check("arst_pre_wrong", pre_wrong, 1'b0);
    check("arst_flush",     flush,     1'b0);
    check("arst_res_ready", res_ready, 1'b0);
    check("arst_bp_ready",  bp_ready,  1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (3) step(idle);

    // ---- random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(I($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
             ($urandom_range(0, 2) != 0) && (mq.size() != 0),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_branch_update_ctrl
`default_nettype wire
